muldiv_unit: RTL and testbench

Iterative multiply/divide unit for the MIPS execute stage; sits beside the ALU, takes operands from register file read ports (rd1, rd2) and holds results in HI/LO for a later mfhi/mflo write-back. Executes MULT, MULTU, DIV and DIVU in the radix-2 shift/add-subtract style. The controller stalls the pipeline on `busy`.

---
 rtl/muldiv_pkg.sv | 23 ++
 rtl/muldiv_addsub.sv | 13 +
 rtl/muldiv_unit.sv | 166 ++++++++++++++++
 tb/tb_muldiv_unit.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - op encodings, FSM states and iteration-count helper for muldiv_unit
package muldiv_pkg;

  localparam int MD_WIDTH = 32;

  localparam logic [1:0] OP_MULTU = 2'b00;
  localparam logic [1:0] OP_MULT  = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [1:0] OP_DIV   = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // Counter load value: one radix-2 iteration per operand bit, counting down to 0.
  function automatic int iter_init(input int width);
    return width - 1;
  endfunction

endpackage

// File: rtl/muldiv_addsub.sv
// rtl/muldiv_addsub.sv - WIDTH+1-bit adder/subtractor shared by multiply add and divide subtract
module muldiv_addsub #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0] x,
  input  logic [WIDTH:0] y,
  input  logic           sub,
  output logic [WIDTH:0] res
);

  assign res = sub ? (x - y) : (x + y);

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative MULT/MULTU/DIV/DIVU unit with HI/LO; optional mthi/mtlo via MULDIV_MTHILO_EN
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef MULDIV_MTHILO_EN
  input  logic [1:0]       hilo_we,
  input  logic [WIDTH-1:0] wd,
`endif
  output logic             busy,
  output logic             done,
  output logic             divz,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_INIT = CW'(iter_init(WIDTH));

  state_t           state, state_nx;
  logic [CW-1:0]    cnt;
  logic             div_q, zdiv_q, neg_q, neg_r;
  logic [WIDTH-1:0] opb_q;   // multiplicand (mult) or divisor (div) magnitude
  logic [WIDTH-1:0] acc_hi;  // product high half / partial remainder
  logic [WIDTH-1:0] acc_lo;  // multiplier shifting out / quotient shifting in

  // Operand decode at the accepting edge
  logic             accept, in_div, in_sgn, in_zdiv, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;

  assign accept  = start && ((state == S_IDLE) || (state == S_DONE));
  assign in_div  = (op == OP_DIVU) || (op == OP_DIV);
  assign in_sgn  = (op == OP_MULT) || (op == OP_DIV);
  assign in_zdiv = in_div && (b == '0);
  assign a_neg   = in_sgn && a[WIDTH-1];
  assign b_neg   = in_sgn && b[WIDTH-1];
  assign a_mag   = a_neg ? (-a) : a;
  assign b_mag   = b_neg ? (-b) : b;

  // Shared datapath: divide subtracts the divisor from the shifted remainder,
  // multiply adds the multiplicand into the high half.
  logic [WIDTH:0]     shifted, as_x, as_y, as_res, mul_sum;
  logic [2*WIDTH-1:0] prod, prod_fix;

  assign shifted  = {acc_hi, acc_lo[WIDTH-1]};
  assign as_x     = div_q ? shifted : {1'b0, acc_hi};
  assign as_y     = {1'b0, opb_q};
  assign mul_sum  = acc_lo[0] ? as_res : as_x;
  assign prod     = {acc_hi, acc_lo};
  assign prod_fix = neg_q ? (-prod) : prod;

  muldiv_addsub #(.WIDTH(WIDTH)) u_addsub (
    .x   (as_x),
    .y   (as_y),
    .sub (div_q),
    .res (as_res)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nx;
  end

  // Next-state and status outputs; divide by zero skips the iteration phase
  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nx = in_zdiv ? S_FIX : S_CALC;
      end
      S_CALC: begin
        busy = 1'b1;
        if (cnt == '0) state_nx = S_FIX;
      end
      S_FIX: begin
        busy     = 1'b1;
        state_nx = S_DONE;
      end
      S_DONE: begin
        done     = 1'b1;
        state_nx = start ? (in_zdiv ? S_FIX : S_CALC) : S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Operand capture, per-cycle iteration, sign fix-up and HI/LO update
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt    <= '0;
      div_q  <= 1'b0;
      zdiv_q <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      opb_q  <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      hi     <= '0;
      lo     <= '0;
      divz   <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (accept) begin
            div_q  <= in_div;
            zdiv_q <= in_zdiv;
            cnt    <= CNT_INIT;
            divz   <= 1'b0;
            neg_q  <= a_neg ^ b_neg;
            neg_r  <= a_neg;
            acc_hi <= '0;
            // Divide by zero keeps the raw dividend so FIX can return it in HI.
            acc_lo <= in_zdiv ? a : (in_div ? a_mag : b_mag);
            opb_q  <= in_div ? b_mag : a_mag;
          end
`ifdef MULDIV_MTHILO_EN
          else begin
            if (hilo_we[1]) hi <= wd;
            if (hilo_we[0]) lo <= wd;
          end
`endif
        end
        S_CALC: begin
          cnt <= cnt - 1'b1;
          if (div_q) begin
            if (!as_res[WIDTH]) begin
              acc_hi <= as_res[WIDTH-1:0];
              acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
            end else begin
              acc_hi <= shifted[WIDTH-1:0];
              acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
            end
          end else begin
            acc_hi <= mul_sum[WIDTH:1];
            acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
          end
        end
        S_FIX: begin
          if (zdiv_q) begin
            hi   <= acc_lo;
            lo   <= '1;
            divz <= 1'b1;
          end else if (div_q) begin
            lo <= neg_q ? (-acc_lo) : acc_lo;
            hi <= neg_r ? (-acc_hi) : acc_hi;
          end else begin
            hi <= prod_fix[2*WIDTH-1:WIDTH];
            lo <= prod_fix[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - scoreboard bench for muldiv_unit with arithmetic reference model
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
`ifdef MULDIV_MTHILO_EN
  logic [1:0]   hilo_we = 2'b00;
  logic [W-1:0] wd = '0;
`endif
  logic         busy, done, divz;
  logic [W-1:0] hi, lo;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .a       (a),
    .b       (b),
`ifdef MULDIV_MTHILO_EN
    .hilo_we (hilo_we),
    .wd      (wd),
`endif
    .busy    (busy),
    .done    (done),
    .divz    (divz),
    .hi      (hi),
    .lo      (lo)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         divz;
    int           due;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: whole-width integer arithmetic, no iteration
  function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t   e;
    longint sx, sy, q, r;
    logic [63:0] p;
    e.divz = 1'b0;
    e.due  = 0;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    if (o[1] && y == 0) begin
      e.hi   = x;
      e.lo   = '1;
      e.divz = 1'b1;
    end else if (o == OP_MULTU) begin
      p = {32'b0, x} * {32'b0, y};
      e.hi = p[63:32];
      e.lo = p[31:0];
    end else if (o == OP_MULT) begin
      p = 64'(sx * sy);
      e.hi = p[63:32];
      e.lo = p[31:0];
    end else if (o == OP_DIVU) begin
      e.lo = x / y;
      e.hi = x % y;
    end else begin
      q = sx / sy;
      r = sx % sy;
      e.lo = q[31:0];
      e.hi = r[31:0];
    end
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding operation
  always @(negedge clk) begin
    if (reset && done) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1 expected no pending op (t=%0t)", $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("hi", hi, e.hi);
        check("lo", lo, e.lo);
        check("divz", divz, e.divz);
        check("done_cycle", cyc, e.due);
        check("busy_in_done", busy, 0);
      end
    end
  end

  // Called just after a negedge with the DUT idle or in DONE
  task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    start = 1'b1;
    op = o;
    a = x;
    b = y;
    @(posedge clk);
    #1;
    e = model(o, x, y);
    e.due = cyc + ((o[1] && y == 0) ? 1 : W + 1);
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    a = $urandom;
    b = $urandom;
    op = 2'($urandom);
  endtask

  task automatic wait_done(output int busy_cycles);
    int k;
    k = 0;
    busy_cycles = 0;
    while (!done && k < 100) begin
      if (busy) busy_cycles++;
      @(negedge clk);
      k++;
    end
    if (!done) begin
      n_chk++;
      n_fail++;
      $display("FAIL done_timeout: got no done expected done within 100 cycles");
    end
  endtask

  int bc;
  logic [W-1:0] prev_lo;

  initial begin
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_divz", divz, 0);
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    reset = 1'b1;
    @(negedge clk);

    issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(bc);
    check("busy_cycles", bc, 33);

    issue(OP_MULT, 32'hFFFF_FFFD, 32'd7);
    wait_done(bc);
    issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    wait_done(bc);
    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(bc);
    repeat (2) @(negedge clk);
    issue(OP_DIVU, 32'd100, 32'd0);
    wait_done(bc);
    issue(OP_MULTU, 32'd3, 32'd4);
    wait_done(bc);

    // Start while busy must be ignored
    repeat (2) @(negedge clk);
    issue(OP_MULTU, 32'd5, 32'd6);
    repeat (4) @(negedge clk);
    start = 1'b1;
    op = OP_MULTU;
    a = 32'd9;
    @(negedge clk);
    start = 1'b0;
    wait_done(bc);

    // Reset in the middle of an operation: abort, no done
    @(negedge clk);
    issue(OP_MULTU, 32'h1234_5678, 32'h9ABC_DEF0);
    repeat (9) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_hi", hi, 0);
    check("midrst_lo", lo, 0);
    sb.delete();
    reset = 1'b1;
    repeat (40) @(negedge clk);

`ifdef MULDIV_MTHILO_EN
    issue(OP_MULTU, 32'd7, 32'd11);
    wait_done(bc);
    @(negedge clk);
    prev_lo = lo;
    hilo_we = 2'b10;
    wd = 32'h1234;
    @(negedge clk);
    hilo_we = 2'b00;
    check("mthi_hi", hi, 32'h1234);
    check("mthi_lo_kept", lo, prev_lo);
    hilo_we = 2'b10;
    wd = 32'h5678;
    issue(OP_MULTU, 32'd2, 32'd3);
    hilo_we = 2'b00;
    check("mthi_with_start_dropped", hi, 32'h1234);
    hilo_we = 2'b11;
    @(negedge clk);
    hilo_we = 2'b00;
    check("mthi_busy_ignored", hi, 32'h1234);
    wait_done(bc);
`endif

    // Randomised operations, with occasional zero divisors and back-to-back starts
    for (int i = 0; i < 40; i++) begin
      logic [1:0]   ro;
      logic [W-1:0] ra, rb;
      ro = 2'($urandom);
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = '0;
        1: ra = 32'h8000_0000;
        2: rb = 32'hFFFF_FFFF;
        3: rb = 32'($urandom_range(1, 9));
        default: ;
      endcase
      issue(ro, ra, rb);
      wait_done(bc);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
